jtpopeye_dma: RTL
=================

# jtpopeye_dma

Sprite DMA initiator for the Popeye board, the other end of the main CPU's DMA port. On each trigger it asks the Z80 for the bus, reads a block of main RAM through the CPU board's DMA port (AD_DMA in, DD_DMA out), and copies it byte by byte into the object buffer. It then hands the bus back to the CPU. It sits between jtpopeye_main and the object/sprite video section.

## Interface
Parameters:
- START, 10'h000, first RAM offset read; the RAM address seen is {1'b1, AD_DMA}.
- LEN, 11'd1024, number of bytes per transfer (0..1024).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cen  in  1  CPU clock enable; the same cen that drives the main RAM.
- start  in  1  trigger pulse; may be asserted on any clk.
- busrq_n  out  1  bus request to the Z80, active-low.
- busak_n  in  1  bus acknowledge from the Z80, active-low.
- dma_cs  out  1  steers the main RAM address mux to AD_DMA.
- AD_DMA  out  10  RAM read offset.
- DD_DMA  in  8  RAM read data, registered by the RAM on cen.
- obj_addr  out  10  object buffer write index, counting from 0.
- obj_data  out  8  object buffer write data.
- obj_we  out  1  object buffer write strobe, one clk wide.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-clk pulse when a transfer completes.
- abort  out  1  one-clk pulse when a transfer is abandoned.

## Operation
- States: IDLE, REQ, READ, DRAIN, RELEASE. All transitions happen on clk edges where cen=1.
- IDLE:
  - start latches a pending flag on any clk.
  - On the next cen with the flag set, clear the flag and go to REQ.
  - If LEN=0, pulse done instead and stay in IDLE.
- REQ: busrq_n=0. When busak_n=0 is sampled on cen, go to READ with AD_DMA=START, dma_cs=1 and the index counter at 0.
- READ: each cen issues the next address, AD_DMA <= AD_DMA+1 (wraps modulo 1024). After LEN addresses have been issued, go to DRAIN.
- DRAIN: lasts one cen so the last byte can come back.
- Write side, in READ and DRAIN: the byte for address k arrives one cen after k was issued. On that cen:
  - obj_data <= DD_DMA;
  - obj_addr <= k-START (mod 1024);
  - obj_we high for that single clk.
- RELEASE:
  - dma_cs=0, busrq_n=1, done pulses on entry.
  - Wait until busak_n=1 is sampled on cen, then go to IDLE.
- busak_n=1 seen in READ or DRAIN (bus lost):
  - go straight to RELEASE;
  - pulse abort instead of done;
  - no further obj_we.
- start while busy: ignored and not queued. The pending flag only sets in IDLE.
- Exactly LEN obj_we strobes per completed transfer, with obj_addr running 0..LEN-1.

## Timing
- Reset values:
  - busrq_n=1, busak_n-dependent logic idle;
  - dma_cs=0, AD_DMA=START, obj_addr=0, obj_data=0;
  - obj_we=0, busy=0, done=0, abort=0;
  - pending flag cleared;
  - state IDLE.
- rst mid-transfer: returns to the reset values on the next clk. busrq_n goes to 1 immediately and no done pulse is produced.
- Latency, counted in cen ticks once start is seen by a cen: REQ entry at +1, then the Z80 acknowledge delay, then LEN+1 ticks through READ and DRAIN, then RELEASE.
- dma_cs rises on the same clk as the first AD_DMA value and falls on RELEASE entry, never before the last data is captured.
- busrq_n stays low from REQ entry until RELEASE entry.
- Every output is registered. There is no combinational path from any input to any output.

## Structure
- No shared package is needed. Put the state encoding in localparams inside the module.
- One sub-module fits naturally: jtpopeye_dma_ctr, a 10-bit wrapping address counter plus an 11-bit remaining-count counter, used for both the issue side and the write side.
- The CPU-board ports connect one-to-one to jtpopeye_main's busrq_n, busak_n, dma_cs, AD_DMA and DD_DMA.

## Test plan
- Model busak_n following busrq_n after 3 cen; use START=0, LEN=4 and RAM bytes 11,22,33,44.
  - Expect obj_we four times with (0,11), (1,22), (2,33), (3,44).
  - Expect done once, then busrq_n=1.
- START=10'h3FE, LEN=4.
  - Expect AD_DMA sequence 3FE, 3FF, 000, 001.
  - Expect obj_addr 0..3.
- LEN=0 with start.
  - Expect a done pulse, busrq_n held at 1, no obj_we.
- Second start pulse during READ.
  - Expect it ignored: one done only, then IDLE with busy=0.
- busak_n forced to 1 after the 2nd obj_we.
  - Expect an abort pulse, no done, exactly 2 writes, dma_cs=0.
- rst asserted in READ.
  - Expect busrq_n=1, dma_cs=0, busy=0 on the next clk.
  - A following start then produces a complete transfer.

Source files
------------

// File: rtl/jtpopeye_dma_ctr.sv
// Address/remaining-count counter pair for the sprite DMA.
// A 10-bit wrapping address counter plus an 11-bit count of steps left.
// The top uses one instance on the issue side (RAM offsets) and one on the
// write side (object buffer index).
module jtpopeye_dma_ctr #(
    parameter logic [9:0] RST_ADDR = 10'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [9:0]  load_addr,
    input  logic [10:0] load_left,
    input  logic        step,
    output logic [9:0]  addr,
    output logic        last
);

    logic [10:0] left;

    // Load a new block descriptor, or advance by one position; load wins over step.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= RST_ADDR;
            left <= 11'd0;
        end else if (load) begin
            addr <= load_addr;
            left <= load_left;
        end else if (step) begin
            addr <= addr + 10'd1;
            left <= left - 11'd1;
        end
    end

    // One step remains: the step taken now is the final one of the block.
    assign last = (left == 11'd1);

endmodule

// File: rtl/jtpopeye_dma.sv
// Sprite DMA initiator for Popeye: grabs the Z80 bus, reads a block of main
// RAM through the CPU board DMA port and copies it into the object buffer.
//
// Bus handshake: busrq_n is driven low from REQ entry until RELEASE entry;
// the bus is ours only while busak_n samples low on cen. busak_n sampled high
// during READ/DRAIN means the bus was lost and the transfer is abandoned.
// RAM data for an offset issued on one cen is captured on the following cen.
module jtpopeye_dma #(
    parameter logic [9:0]  START = 10'h000,
    parameter logic [10:0] LEN   = 11'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    output logic       busrq_n,
    input  logic       busak_n,
    output logic       dma_cs,
    output logic [9:0] AD_DMA,
    input  logic [7:0] DD_DMA,
    output logic [9:0] obj_addr,
    output logic [7:0] obj_data,
    output logic       obj_we,
    output logic       busy,
    output logic       done,
    output logic       abort
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_READ    = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        REQ     = ST_REQ,
        READ    = ST_READ,
        DRAIN   = ST_DRAIN,
        RELEASE = ST_RELEASE
    } state_t;

    // Issue side starts with START already presented, so it counts the rest.
    localparam logic [10:0] LEN_M1 = LEN - 11'd1;

    state_t     state, state_nx;
    logic       pending, pending_nx;
    logic       busrq_nx, dma_cs_nx, busy_nx;
    logic       done_nx, abort_nx, we_nx;
    logic [9:0] oaddr_nx;
    logic [7:0] odata_nx;
    logic       iss_load, iss_step, iss_last;
    logic       wr_load, wr_step, wr_last;
    logic [9:0] wr_addr;

    jtpopeye_dma_ctr #(.RST_ADDR(START)) u_iss (
        .clk       (clk),
        .rst       (rst),
        .load      (iss_load),
        .load_addr (START),
        .load_left (LEN_M1),
        .step      (iss_step),
        .addr      (AD_DMA),
        .last      (iss_last)
    );

    jtpopeye_dma_ctr #(.RST_ADDR(10'h000)) u_wr (
        .clk       (clk),
        .rst       (rst),
        .load      (wr_load),
        .load_addr (10'h000),
        .load_left (LEN),
        .step      (wr_step),
        .addr      (wr_addr),
        .last      (wr_last)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        busrq_nx   = busrq_n;
        dma_cs_nx  = dma_cs;
        done_nx    = 1'b0;
        abort_nx   = 1'b0;
        we_nx      = 1'b0;
        oaddr_nx   = obj_addr;
        odata_nx   = obj_data;
        iss_load   = 1'b0;
        iss_step   = 1'b0;
        wr_load    = 1'b0;
        wr_step    = 1'b0;

        if (start && state == IDLE) pending_nx = 1'b1;

        if (cen) begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        pending_nx = 1'b0;
                        if (LEN == 11'd0) begin
                            done_nx = 1'b1;
                        end else begin
                            state_nx = REQ;
                            busrq_nx = 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        iss_load  = 1'b1;
                        wr_load   = 1'b1;
                        dma_cs_nx = 1'b1;
                        state_nx  = (LEN == 11'd1) ? DRAIN : READ;
                    end
                end
                READ, DRAIN: begin
                    if (busak_n) begin
                        state_nx  = RELEASE;
                        abort_nx  = 1'b1;
                        dma_cs_nx = 1'b0;
                        busrq_nx  = 1'b1;
                    end else begin
                        we_nx    = 1'b1;
                        odata_nx = DD_DMA;
                        oaddr_nx = wr_addr;
                        wr_step  = 1'b1;
                        if (state == READ) begin
                            iss_step = 1'b1;
                            if (iss_last) state_nx = DRAIN;
                        end else begin
                            state_nx  = RELEASE;
                            done_nx   = wr_last;
                            dma_cs_nx = 1'b0;
                            busrq_nx  = 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (busak_n) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end

        busy_nx = (state_nx != IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            busrq_n  <= 1'b1;
            dma_cs   <= 1'b0;
            obj_addr <= 10'h000;
            obj_data <= 8'h00;
            obj_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            busrq_n  <= busrq_nx;
            dma_cs   <= dma_cs_nx;
            obj_addr <= oaddr_nx;
            obj_data <= odata_nx;
            obj_we   <= we_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            abort    <= abort_nx;
        end
    end

endmodule
